if_id_decode: RTL and testbench
===============================

Name: if_id_decode

Overview:
Pipeline stage directly downstream of instruction fetch. It latches the fetched PC and instruction into the IF/ID register and reads the register file (GRF, internal), with bypassing from MEM and WB. It resolves branches and jumps in ID (one delay slot) and drives the fetch redirect and stall signals back to fetch. It also registers the decoded operand bundle into the ID/EX latch for the execute stage.

Parameters:
PC_START, 32'h0000_3000, reset PC held in the IF/ID and ID/EX latches
GRF_DEPTH, 32, number of general registers; $0 hard-wired to zero

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high
if_pc  in  32  PC of fetched instruction
if_instr  in  32  fetched instruction
ex_reg_write  in  1  instruction in EX writes GRF
ex_dst  in  5  EX destination register
ex_is_load  in  1  EX instruction is lw
mem_reg_write  in  1  instruction in MEM writes GRF
mem_dst  in  5  MEM destination register
mem_is_load  in  1  MEM instruction is lw (data not yet forwardable)
mem_fwd_data  in  32  MEM ALU result / link value
wb_reg_write  in  1  GRF write enable
wb_dst  in  5  GRF write address
wb_data  in  32  GRF write data
stall  out  1  to fetch: hold PC; internally holds IF/ID
isBranch  out  1  to fetch: taken conditional branch
branchAddr  out  32  sign-extended imm16 (word offset; fetch shifts by 2)
isJump  out  1  j / jal
jumpAddr  out  26  instr_index
isJumpReg  out  1  jr / jalr
jumpRegAddr  out  32  forwarded rs value
ex_pc  out  32  ID/EX latched PC
ex_instr  out  32  ID/EX latched instruction (0 = bubble)
ex_rs_data  out  32  ID/EX forwarded rs value
ex_rt_data  out  32  ID/EX forwarded rt value
ex_imm_ext  out  32  ID/EX sign-extended imm16

Behaviour:
- Reset (asynchronous): IF/ID pc=PC_START, instr=0; all GRF entries 0; ID/EX pc=PC_START, all other ex_* 0. All control outputs are combinational on instr=0 and are therefore 0.
- IF/ID update on posedge: if stall, hold; else latch if_pc/if_instr. There is no flush; the delay-slot instruction always executes.
- GRF: written on posedge when wb_reg_write && wb_dst!=0. Writes to $0 are ignored and reads of $0 return 0.
- Operand value (rs, rt), priority highest first:
  - 0 if the register index is 0.
  - mem_fwd_data if mem_reg_write && !mem_is_load && mem_dst==idx.
  - wb_data if wb_reg_write && wb_dst==idx (same-cycle write/read bypass).
  - GRF contents otherwise.
- Decoded branch/jump set: beq, bne, blez, bgtz, j, jal, jr, jalr. Opcode and funct constants are the codebase values.
- Stall (combinational). Assert when ID uses register r≠0 and any of the following holds:
  - ex_reg_write && ex_dst==r && (ex_is_load || the ID instruction is a branch/jr/jalr).
  - mem_reg_write && mem_is_load && mem_dst==r && the ID instruction is a branch/jr/jalr.
- Usage: rs is used by all R-type, I-type, branches, jr and jalr. rt is used by R-type, beq, bne and sw.
- On stall:
  - isBranch, isJump and isJumpReg are forced to 0.
  - ID/EX loads a bubble: ex_instr=0, other data fields 0, ex_pc=IF/ID pc.
- Branch conditions use the 32-bit signed forwarded values:
  - beq: rs==rt.
  - bne: rs!=rt.
  - blez: rs<=0.
  - bgtz: rs>0.
- branchAddr = {{16{imm[15]}}, imm} whenever a branch is taken; 0 otherwise.
- jumpAddr = instr[25:0] when isJump, else 0. jumpRegAddr = forwarded rs when isJumpReg, else 0.
- At most one of isBranch, isJump, isJumpReg is high in any cycle.
- ID/EX update, when not stalled: latch pc, instr, forwarded rs/rt and imm_ext. Latency from IF/ID to ex_* is 1 cycle.
- Reset asserted mid-stall clears both latches immediately. The first cycle after deassertion outputs a nop.

Decomposition:
- constant.vh: opcode/funct localparams (OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL, OP_SPECIAL, FN_JR, FN_JALR) and PC_START.
- Sub-module grf: 32x32 storage with async reset, two combinational read ports and one write port. It has no internal bypass; the bypass is done in if_id_decode.

Test Plan:
- Reset pulse asserted between clock edges -> ex_instr=0, ex_pc=32'h3000, stall/isBranch/isJump/isJumpReg=0 without waiting for a clock edge.
- WB writes $1=5 and $2=5; ID holds beq $1,$2,+3 -> isBranch=1, branchAddr=32'h0000_0003; with $2=6 -> isBranch=0.
- bne $1,$0 with imm=16'hFFFE and $1=7 -> isBranch=1, branchAddr=32'hFFFF_FFFE.
- EX lw $8 (ex_is_load=1, ex_dst=8); ID addu $9,$8,$8 -> stall=1 for exactly one cycle; ex_instr=0 in the next cycle; IF/ID held; the following cycle passes addu.
- MEM non-load writes $31 with mem_fwd_data=32'h0000_3040; ID jr $31 -> isJumpReg=1, jumpRegAddr=32'h3040, stall=0. Same with ex_reg_write, ex_dst=31 -> stall=1, isJumpReg=0.
- wb writes $5=32'hDEAD_BEEF in the same cycle ID reads $5 -> ex_rs_data=32'hDEADBEEF. A wb write to $0 leaves reads of $0 at 0.

Source files
------------

// File: rtl/if_id_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_decode_pkg
// Description : Shared constants and helpers for the IF/ID decode stage.
//               This package holds the opcode and funct encodings, the reset PC,
//               the operand-forwarding select and the per-register hazard test.
// Revision    : 1.0 - initial release
// ============================================================================
package if_id_decode_pkg;

  localparam logic [31:0] PC_START_DEFAULT  = 32'h0000_3000;
  localparam int          GRF_DEPTH_DEFAULT = 32;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;

  // Operand value with bypass. The MEM stage has priority over WB because MEM
  // holds the younger producer. A load sitting in MEM has no data yet, so it
  // is never forwarded from that stage.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  idx,
    input logic        mem_rw,
    input logic        mem_ld,
    input logic [4:0]  mem_dst,
    input logic [31:0] mem_data,
    input logic        wb_rw,
    input logic [4:0]  wb_dst,
    input logic [31:0] wb_data,
    input logic [31:0] grf_data
  );
    logic [31:0] v;
    if (idx == 5'd0)                                   v = 32'd0;
    else if (mem_rw && !mem_ld && (mem_dst == idx))    v = mem_data;
    else if (wb_rw && (wb_dst == idx))                 v = wb_data;
    else                                               v = grf_data;
    return v;
  endfunction

  // Returns 1 when register r cannot yet be supplied to ID.
  // A load in EX always blocks. Any EX producer blocks an ID-resolved
  // consumer (a branch or a jr/jalr), because the ALU result is not
  // available until the end of the cycle. A load in MEM blocks only
  // those same ID-resolved consumers.
  function automatic logic reg_hazard(
    input logic [4:0] r,
    input logic       ex_rw,
    input logic [4:0] ex_dst,
    input logic       ex_ld,
    input logic       mem_rw,
    input logic [4:0] mem_dst,
    input logic       mem_ld,
    input logic       id_resolve
  );
    logic h;
    h = 1'b0;
    if (r != 5'd0) begin
      if (ex_rw && (ex_dst == r) && (ex_ld || id_resolve))   h = 1'b1;
      if (mem_rw && mem_ld && (mem_dst == r) && id_resolve)  h = 1'b1;
    end
    return h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_decode_grf.sv
`default_nettype none
// ============================================================================
// Module      : if_id_decode_grf
// Description : General register file with 32-bit entries. It has two
//               combinational read ports and one synchronous write port.
//               Writes to entry 0 are dropped. There is no internal bypass.
// Ports       : clk, rst          - clock and async active-high reset
//               i_we/i_waddr/i_wdata - write port
//               i_raddr_a/o_rdata_a  - read port A
//               i_raddr_b/o_rdata_b  - read port B
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_decode_grf #(
  parameter int GRF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr_a,
  output logic [31:0] o_rdata_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_b
);

  logic [31:0] r_mem [GRF_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < GRF_DEPTH; i++) r_mem[i] <= 32'd0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/if_id_decode.sv
`default_nettype none
// ============================================================================
// Module      : if_id_decode
// Description : IF/ID latch, register read with MEM/WB bypass, branch and
//               jump resolution in ID (one delay slot, no flush), hazard
//               stall, and the ID/EX operand latch.
// Ports       : clk, reset                - clock and async active-high reset
//               if_pc, if_instr           - from fetch
//               ex_*/mem_*/wb_* (inputs)  - downstream producer state
//               stall, isBranch, branchAddr, isJump, jumpAddr,
//               isJumpReg, jumpRegAddr    - redirect and stall to fetch
//               ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm_ext
//                                         - ID/EX latch to execute
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_decode
  import if_id_decode_pkg::*;
#(
  parameter logic [31:0] PC_START  = PC_START_DEFAULT,
  parameter int          GRF_DEPTH = GRF_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_dst,
  input  logic        ex_is_load,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_dst,
  input  logic        mem_is_load,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_dst,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        isBranch,
  output logic [31:0] branchAddr,
  output logic        isJump,
  output logic [25:0] jumpAddr,
  output logic        isJumpReg,
  output logic [31:0] jumpRegAddr,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm_ext
);

  // IF/ID latch
  logic [31:0] r_id_pc;
  logic [31:0] r_id_instr;

  // Decode fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [5:0]  w_funct;
  logic [15:0] w_imm;
  logic [31:0] w_imm_ext;

  logic        w_is_beq, w_is_bne, w_is_blez, w_is_bgtz;
  logic        w_is_cond_br, w_is_j, w_is_jr;
  logic        w_id_resolve;
  logic        w_rs_used, w_rt_used;
  logic        w_br_taken;
  logic        w_stall;

  logic [31:0] w_grf_rs, w_grf_rt;
  logic [31:0] w_rs_val, w_rt_val;

  assign w_op      = r_id_instr[31:26];
  assign w_rs      = r_id_instr[25:21];
  assign w_rt      = r_id_instr[20:16];
  assign w_funct   = r_id_instr[5:0];
  assign w_imm     = r_id_instr[15:0];
  assign w_imm_ext = {{16{w_imm[15]}}, w_imm};

  assign w_is_beq     = (w_op == OP_BEQ);
  assign w_is_bne     = (w_op == OP_BNE);
  assign w_is_blez    = (w_op == OP_BLEZ);
  assign w_is_bgtz    = (w_op == OP_BGTZ);
  assign w_is_cond_br = w_is_beq | w_is_bne | w_is_blez | w_is_bgtz;
  assign w_is_j       = (w_op == OP_J) | (w_op == OP_JAL);
  assign w_is_jr      = (w_op == OP_SPECIAL) &&
                        ((w_funct == FN_JR) || (w_funct == FN_JALR));
  assign w_id_resolve = w_is_cond_br | w_is_jr;

  // Every format except j/jal reads rs. rt is read as a source only by
  // R-type, beq/bne and sw; for other I-types it is the destination.
  assign w_rs_used = !w_is_j;
  assign w_rt_used = (w_op == OP_SPECIAL) | w_is_beq | w_is_bne | (w_op == OP_SW);

  if_id_decode_grf #(
    .GRF_DEPTH (GRF_DEPTH)
  ) u_grf (
    .clk       (clk),
    .rst       (reset),
    .i_we      (wb_reg_write),
    .i_waddr   (wb_dst),
    .i_wdata   (wb_data),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_grf_rs),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_grf_rt)
  );

  assign w_rs_val = fwd_sel(w_rs, mem_reg_write, mem_is_load, mem_dst, mem_fwd_data,
                            wb_reg_write, wb_dst, wb_data, w_grf_rs);
  assign w_rt_val = fwd_sel(w_rt, mem_reg_write, mem_is_load, mem_dst, mem_fwd_data,
                            wb_reg_write, wb_dst, wb_data, w_grf_rt);

  assign w_stall =
      (w_rs_used && reg_hazard(w_rs, ex_reg_write, ex_dst, ex_is_load,
                               mem_reg_write, mem_dst, mem_is_load, w_id_resolve)) ||
      (w_rt_used && reg_hazard(w_rt, ex_reg_write, ex_dst, ex_is_load,
                               mem_reg_write, mem_dst, mem_is_load, w_id_resolve));

  always_comb begin
    w_br_taken = 1'b0;
    if (w_is_beq)  w_br_taken = (w_rs_val == w_rt_val);
    if (w_is_bne)  w_br_taken = (w_rs_val != w_rt_val);
    if (w_is_blez) w_br_taken = ($signed(w_rs_val) <= 32'sd0);
    if (w_is_bgtz) w_br_taken = ($signed(w_rs_val) >  32'sd0);
  end

  // Redirects are suppressed during a stall because the operands are stale.
  assign stall       = w_stall;
  assign isBranch    = w_br_taken & ~w_stall;
  assign branchAddr  = isBranch  ? w_imm_ext : 32'd0;
  assign isJump      = w_is_j    & ~w_stall;
  assign jumpAddr    = isJump    ? r_id_instr[25:0] : 26'd0;
  assign isJumpReg   = w_is_jr   & ~w_stall;
  assign jumpRegAddr = isJumpReg ? w_rs_val : 32'd0;

  // IF/ID: hold while stalled; never flushed, so the delay slot executes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id_pc    <= PC_START;
      r_id_instr <= 32'd0;
    end else if (!w_stall) begin
      r_id_pc    <= if_pc;
      r_id_instr <= if_instr;
    end
  end

  // ID/EX: a stall inserts a bubble but keeps the PC of the held instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_pc      <= PC_START;
      ex_instr   <= 32'd0;
      ex_rs_data <= 32'd0;
      ex_rt_data <= 32'd0;
      ex_imm_ext <= 32'd0;
    end else if (w_stall) begin
      ex_pc      <= r_id_pc;
      ex_instr   <= 32'd0;
      ex_rs_data <= 32'd0;
      ex_rt_data <= 32'd0;
      ex_imm_ext <= 32'd0;
    end else begin
      ex_pc      <= r_id_pc;
      ex_instr   <= r_id_instr;
      ex_rs_data <= w_rs_val;
      ex_rt_data <= w_rt_val;
      ex_imm_ext <= w_imm_ext;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_decode
// Description : Directed self-checking bench for if_id_decode.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_decode;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc, if_instr;
  logic        ex_reg_write, ex_is_load;
  logic [4:0]  ex_dst;
  logic        mem_reg_write, mem_is_load;
  logic [4:0]  mem_dst;
  logic [31:0] mem_fwd_data;
  logic        wb_reg_write;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        stall, isBranch, isJump, isJumpReg;
  logic [31:0] branchAddr, jumpRegAddr;
  logic [25:0] jumpAddr;
  logic [31:0] ex_pc, ex_instr, ex_rs_data, ex_rt_data, ex_imm_ext;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_id_decode dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr),
    .ex_reg_write(ex_reg_write), .ex_dst(ex_dst), .ex_is_load(ex_is_load),
    .mem_reg_write(mem_reg_write), .mem_dst(mem_dst), .mem_is_load(mem_is_load),
    .mem_fwd_data(mem_fwd_data), .wb_reg_write(wb_reg_write), .wb_dst(wb_dst),
    .wb_data(wb_data), .stall(stall), .isBranch(isBranch), .branchAddr(branchAddr),
    .isJump(isJump), .jumpAddr(jumpAddr), .isJumpReg(isJumpReg),
    .jumpRegAddr(jumpRegAddr), .ex_pc(ex_pc), .ex_instr(ex_instr),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm_ext(ex_imm_ext)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_addu(input logic [4:0] rd, rs, rt);
    return {6'h00, rs, rt, rd, 5'd0, 6'h21};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_jr(input logic [4:0] rs);
    return {6'h00, rs, 15'd0, 6'h08};
  endfunction

  // Inputs change 1 time unit after the rising edge; checks follow later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [4:0] r, input logic [31:0] v);
    wb_reg_write = 1'b1; wb_dst = r; wb_data = v;
    tick();
    wb_reg_write = 1'b0; wb_dst = 5'd0; wb_data = 32'd0;
  endtask

  task automatic load_id(input logic [31:0] pc, input logic [31:0] instr);
    if_pc = pc; if_instr = instr;
    tick();
  endtask

  logic [31:0] addu_989;
  logic [31:0] addu_650;

  initial begin
    reset = 1'b1;
    if_pc = 32'd0; if_instr = 32'd0;
    ex_reg_write = 1'b0; ex_dst = 5'd0; ex_is_load = 1'b0;
    mem_reg_write = 1'b0; mem_dst = 5'd0; mem_is_load = 1'b0; mem_fwd_data = 32'd0;
    wb_reg_write = 1'b0; wb_dst = 5'd0; wb_data = 32'd0;
    addu_989 = enc_addu(5'd9, 5'd8, 5'd8);
    addu_650 = enc_addu(5'd6, 5'd5, 5'd0);

    // Fill both latches with live state, then reset between clock edges.
    #12 reset = 1'b0;
    tick();
    load_id(32'h0000_0100, enc_addu(5'd3, 5'd1, 5'd2));
    load_id(32'h0000_0104, enc_i(6'h04, 5'd1, 5'd1, 16'd4));
    #3 reset = 1'b1;
    #1;
    check("rst_ex_instr", ex_instr, 32'd0);
    check("rst_ex_pc", ex_pc, 32'h0000_3000);
    check("rst_ctrl", {28'd0, stall, isBranch, isJump, isJumpReg}, 32'd0);
    #2 reset = 1'b0;
    if_pc = 32'h0000_3000; if_instr = 32'd0;
    tick();

    // beq: taken when the operands are equal, not taken otherwise.
    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd5);
    load_id(32'h0000_3000, enc_i(6'h04, 5'd1, 5'd2, 16'd3));
    check("beq_taken", {31'd0, isBranch}, 32'd1);
    check("beq_addr", branchAddr, 32'h0000_0003);
    wb_write(5'd2, 32'd6);
    check("beq_not_taken", {31'd0, isBranch}, 32'd0);
    check("beq_addr_nt", branchAddr, 32'd0);

    // bne with a negative offset.
    wb_write(5'd1, 32'd7);
    load_id(32'h0000_3004, enc_i(6'h05, 5'd1, 5'd0, 16'hFFFE));
    check("bne_taken", {31'd0, isBranch}, 32'd1);
    check("bne_addr", branchAddr, 32'hFFFF_FFFE);

    // bgtz and blez against $1=7.
    load_id(32'h0000_3008, enc_i(6'h07, 5'd1, 5'd0, 16'd2));
    check("bgtz_taken", {31'd0, isBranch}, 32'd1);
    load_id(32'h0000_300C, enc_i(6'h06, 5'd1, 5'd0, 16'd2));
    check("blez_not_taken", {31'd0, isBranch}, 32'd0);

    // Load-use: a lw in EX feeds addu in ID.
    load_id(32'h0000_3010, addu_989);
    ex_reg_write = 1'b1; ex_dst = 5'd8; ex_is_load = 1'b1;
    if_pc = 32'h0000_3014; if_instr = enc_addu(5'd10, 5'd0, 5'd0);
    #1;
    check("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    check("lu_bubble", ex_instr, 32'd0);
    check("lu_bubble_pc", ex_pc, 32'h0000_3010);
    ex_reg_write = 1'b0; ex_dst = 5'd0; ex_is_load = 1'b0;
    mem_reg_write = 1'b1; mem_dst = 5'd8; mem_is_load = 1'b1;
    #1;
    check("lu_stall_once", {31'd0, stall}, 32'd0);
    tick();
    check("lu_pass", ex_instr, addu_989);
    check("lu_pass_pc", ex_pc, 32'h0000_3010);
    mem_reg_write = 1'b0; mem_dst = 5'd0; mem_is_load = 1'b0;

    // jr with the target forwarded from a MEM non-load.
    mem_reg_write = 1'b1; mem_dst = 5'd31; mem_fwd_data = 32'h0000_3040;
    load_id(32'h0000_3020, enc_jr(5'd31));
    check("jr_taken", {31'd0, isJumpReg}, 32'd1);
    check("jr_addr", jumpRegAddr, 32'h0000_3040);
    check("jr_no_stall", {31'd0, stall}, 32'd0);
    check("jr_excl", {30'd0, isBranch, isJump}, 32'd0);
    ex_reg_write = 1'b1; ex_dst = 5'd31;
    #1;
    check("jr_ex_stall", {31'd0, stall}, 32'd1);
    check("jr_suppressed", {31'd0, isJumpReg}, 32'd0);
    ex_reg_write = 1'b0; ex_dst = 5'd0;
    mem_reg_write = 1'b0; mem_dst = 5'd0; mem_fwd_data = 32'd0;

    // A load in MEM stalls a branch that reads its destination.
    mem_reg_write = 1'b1; mem_dst = 5'd1; mem_is_load = 1'b1;
    load_id(32'h0000_3024, enc_i(6'h04, 5'd1, 5'd2, 16'd1));
    check("br_memld_stall", {31'd0, stall}, 32'd1);
    check("br_memld_nobr", {31'd0, isBranch}, 32'd0);
    mem_reg_write = 1'b0; mem_dst = 5'd0; mem_is_load = 1'b0;

    // j
    load_id(32'h0000_3028, {6'h02, 26'h0000C40});
    check("j_taken", {31'd0, isJump}, 32'd1);
    check("j_addr", {6'd0, jumpAddr}, 32'h0000_0C40);

    // WB bypass in the same cycle as the ID read.
    load_id(32'h0000_3030, addu_650);
    wb_reg_write = 1'b1; wb_dst = 5'd5; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_reg_write = 1'b0; wb_dst = 5'd0; wb_data = 32'd0;
    check("wb_bypass_rs", ex_rs_data, 32'hDEAD_BEEF);
    check("wb_bypass_imm", ex_imm_ext, 32'h0000_3021);
    check("wb_bypass_instr", ex_instr, addu_650);

    // A write to $0 is ignored.
    wb_write(5'd0, 32'h1234_5678);
    load_id(32'h0000_3034, enc_addu(5'd7, 5'd0, 5'd0));
    tick();
    check("r0_rs", ex_rs_data, 32'd0);
    check("r0_rt", ex_rt_data, 32'd0);

    // Reset during a stall clears both latches, and the next cycle is a nop.
    load_id(32'h0000_3038, addu_989);
    ex_reg_write = 1'b1; ex_dst = 5'd8; ex_is_load = 1'b1;
    #1;
    check("mid_stall_pre", {31'd0, stall}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_instr", ex_instr, 32'd0);
    check("mid_rst_pc", ex_pc, 32'h0000_3000);
    #2 reset = 1'b0;
    ex_reg_write = 1'b0; ex_dst = 5'd0; ex_is_load = 1'b0;
    if_pc = 32'h0000_3000; if_instr = enc_addu(5'd4, 5'd1, 5'd1);
    tick();
    check("post_rst_nop", ex_instr, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
